// File: rtl/mult_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mult_accumulator
// Purpose  : Takes the stream of signed products from the multiplier and adds
//            exactly COUNT accepted products per job into a saturating
//            accumulator. The result is published with a one-cycle done pulse.
//            A start/busy handshake lets a controller run jobs one after
//            another.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous, active-high reset
//            start_i      - begin a new job (sampled only when idle)
//            prod_i       - signed product, PROD_W bits
//            prod_valid_i - prod_i is valid this cycle
//            busy_o       - a job is in progress
//            acc_out_o    - signed result of the last completed job, ACC_W bits
//            done_o       - one-cycle pulse, acc_out_o has just been updated
//            overflow_o   - the current/last job saturated (sticky per job)
// Revision : 1.0 - initial release
// ============================================================================
module mult_accumulator #(
  parameter int PROD_W = 36,
  parameter int ACC_W  = 48,
  parameter int COUNT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              prod_valid_i,
  output logic              busy_o,
  output logic [ACC_W-1:0]  acc_out_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam int CNT_W = $clog2(COUNT) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             done_q, done_d;

  logic             w_accept;
  logic             w_last;
  logic [ACC_W:0]   w_prod_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_sum_ovf;

  assign w_accept = (state_q == S_ACC) && prod_valid_i;
  assign w_last   = w_accept && (count_q == LAST_CNT);

  // One guard bit above ACC_W: the sum overflowed the ACC_W range exactly
  // when the guard bit and the ACC_W sign bit disagree.
  assign w_prod_ext = {{(ACC_W + 1 - PROD_W){prod_i[PROD_W-1]}}, prod_i};
  assign w_sum      = {acc_q[ACC_W-1], acc_q} + w_prod_ext;
  assign w_sum_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_ACC;
      S_ACC:   if (w_last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy_o = (state_q == S_ACC);
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    acc_d     = acc_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    acc_out_d = acc_out_q;
    done_d    = 1'b0;

    if ((state_q == S_IDLE) && start_i) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (w_accept) begin
      count_d = count_q + CNT_W'(1);
      // After saturation the clamp value is frozen; products only advance
      // the count so the job still ends after COUNT accepts.
      if (!ovf_q) begin
        if (w_sum_ovf) begin
          acc_d = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
          ovf_d = 1'b1;
        end else begin
          acc_d = w_sum[ACC_W-1:0];
        end
      end
      if (w_last) begin
        acc_out_d = acc_d;
        done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      acc_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      acc_out_q <= acc_out_d;
      done_q    <= done_d;
    end
  end

  assign acc_out_o  = acc_out_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_accumulator
// Purpose  : Directed self-checking bench for mult_accumulator. Instance A
//            uses the default sizes; instance B uses ACC_W=40, COUNT=32 to
//            exercise saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_accumulator;

  logic        clk;
  logic        rst;

  logic        start_a, valid_a;
  logic [35:0] prod_a;
  logic        busy_a, done_a, ovf_a;
  logic [47:0] acc_a;

  logic        start_b, valid_b;
  logic [35:0] prod_b;
  logic        busy_b, done_b, ovf_b;
  logic [39:0] acc_b;

  int n_tests = 0;
  int n_fail  = 0;

  mult_accumulator #(.PROD_W(36), .ACC_W(48), .COUNT(8)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_a),
    .prod_i       (prod_a),
    .prod_valid_i (valid_a),
    .busy_o       (busy_a),
    .acc_out_o    (acc_a),
    .done_o       (done_a),
    .overflow_o   (ovf_a)
  );

  mult_accumulator #(.PROD_W(36), .ACC_W(40), .COUNT(32)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_b),
    .prod_i       (prod_b),
    .prod_valid_i (valid_b),
    .busy_o       (busy_b),
    .acc_out_o    (acc_b),
    .done_o       (done_b),
    .overflow_o   (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    int done_cnt;
    int done_at;

    rst = 1'b1;
    start_a = 1'b0; valid_a = 1'b0; prod_a = '0;
    start_b = 1'b0; valid_b = 1'b0; prod_b = '0;
    tick; tick;
    check("rst_busy",  64'(busy_a), 64'd0);
    check("rst_done",  64'(done_a), 64'd0);
    check("rst_ovf",   64'(ovf_a),  64'd0);
    check("rst_acc",   64'(acc_a),  64'd0);
    rst = 1'b0;
    tick;

    // ---- Basic job: 1..8 back-to-back -> 36 ----
    start_a = 1'b1; tick; start_a = 1'b0;
    check("basic_busy", 64'(busy_a), 64'd1);
    valid_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      prod_a = 36'(k);
      tick;
      if (k == 7) check("basic_early_done", 64'(done_a), 64'd0);
    end
    check("basic_done", 64'(done_a), 64'd1);
    check("basic_acc",  64'(acc_a),  64'd36);
    check("basic_busy_low", 64'(busy_a), 64'd0);
    check("basic_ovf",  64'(ovf_a),  64'd0);

    // ---- Back-to-back: start in done cycle with an ignored product ----
    start_a = 1'b1; valid_a = 1'b1; prod_a = 36'd99;
    tick;
    start_a = 1'b0;
    check("b2b_done_fall", 64'(done_a), 64'd0);
    check("b2b_busy", 64'(busy_a), 64'd1);
    check("b2b_acc_hold", 64'(acc_a), 64'd36);
    prod_a = 36'hF_FFFF_FFFF;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (k == 7) check("b2b_early_done", 64'(done_a), 64'd0);
    end
    check("b2b_done", 64'(done_a), 64'd1);
    check("b2b_acc",  64'(acc_a),  64'h0000_FFFF_FFFF_FFF8);
    valid_a = 1'b0;
    tick;

    // ---- Reset mid-job ----
    start_a = 1'b1; tick; start_a = 1'b0;
    valid_a = 1'b1; prod_a = 36'd7;
    tick; tick; tick;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_acc",  64'(acc_a),  64'd0);
    check("mid_rst_ovf",  64'(ovf_a),  64'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (done_a) done_cnt++;
    end
    check("mid_rst_no_done", 64'(done_cnt), 64'd0);
    valid_a = 1'b0;

    // ---- Sign extension: 4x -2^35 then 4x 0 ----
    start_a = 1'b1; tick; start_a = 1'b0;
    valid_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      prod_a = (k < 4) ? 36'h8_0000_0000 : 36'h0;
      tick;
    end
    valid_a = 1'b0;
    check("sext_done", 64'(done_a), 64'd1);
    check("sext_acc",  64'(acc_a),  64'h0000_FFE0_0000_0000);
    tick;

    // ---- Gaps with start pulses mid-job ----
    start_a = 1'b1; tick; start_a = 1'b0;
    done_cnt = 0;
    done_at  = -1;
    prod_a   = 36'd5;
    for (int i = 0; i < 20; i++) begin
      valid_a = (i < 16) && (i % 2 == 0);
      start_a = (i % 2 == 1) && (i < 13);
      tick;
      if (done_a) begin
        done_cnt++;
        done_at = i;
      end
      if (i == 15) check("gap_acc_hold", 64'(acc_a), 64'd40);
    end
    start_a = 1'b0; valid_a = 1'b0;
    check("gap_acc",     64'(acc_a),    64'd40);
    check("gap_done_cnt", 64'(done_cnt), 64'd1);
    check("gap_done_at", 64'(done_at),  64'd14);
    check("gap_idle",    64'(busy_a),   64'd0);

    // ---- Saturation on instance B ----
    start_b = 1'b1; tick; start_b = 1'b0;
    valid_b = 1'b1; prod_b = 36'h7_FFFF_FFFF;
    for (int k = 1; k <= 32; k++) begin
      tick;
      if (k == 16) check("sat_ovf_before", 64'(ovf_b), 64'd0);
      if (k == 17) check("sat_ovf_cross",  64'(ovf_b), 64'd1);
      if (k == 31) check("sat_early_done", 64'(done_b), 64'd0);
    end
    valid_b = 1'b0;
    check("sat_done", 64'(done_b), 64'd1);
    check("sat_acc",  64'(acc_b),  64'h00_7F_FFFF_FFFF);
    check("sat_ovf_end", 64'(ovf_b), 64'd1);
    tick;
    check("sat_ovf_sticky", 64'(ovf_b), 64'd1);
    start_b = 1'b1; tick; start_b = 1'b0;
    check("sat_ovf_clear", 64'(ovf_b), 64'd0);
    check("sat_busy",      64'(busy_b), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
